// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-master memory bus arbiter: FSM states and master indices.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/mem_arb_timer.sv
// BUSY-phase watchdog: counts while enabled, clears on demand and flags the last allowed cycle.
// A TIMEOUT_CYCLES of 0 disables the watchdog; expired then stays 0.
module mem_arb_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments and resets asynchronously on rst_n low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && (count == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-transaction-at-a-time memory bus arbiter with a timeout on stalled accesses.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise m0 has fixed priority.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_rd_en_i,
  input  logic                  m0_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_rd_en_i,
  input  logic                  m1_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  mem_rd_en_o,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_ack_i
);

  state_t                state, state_nxt;
  logic                  owner;
  logic                  op_wr;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] m0_data_q, m1_data_q;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  req0, req1;
  logic                  grant;
  logic                  timer_expired;
  logic                  done;

  assign req0 = m0_rd_en_i | m0_wr_en_i;
  assign req1 = m1_rd_en_i | m1_wr_en_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ptr;

  assign grant = (req0 && req1) ? rr_ptr : (req0 ? M0 : M1);

  // Hand the next tie to whoever did not just finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= M0;
    end else if (state == RESP) begin
      rr_ptr <= ~owner;
    end
  end
`else
  assign grant = req0 ? M0 : M1;
`endif

  mem_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state != BUSY),
    .en     (state == BUSY),
    .expired(timer_expired)
  );

  // An acknowledge always beats a timeout landing in the same cycle.
  assign done     = mem_ack_i || timer_expired;
  assign cap_data = (mem_ack_i && !op_wr) ? mem_data_i : '0;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req0 || req1) state_nxt = BUSY;
      BUSY:    if (done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= M0;
      op_wr     <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      m0_data_q <= '0;
      m1_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (req0 || req1)) begin
        owner   <= grant;
        op_wr   <= (grant == M1) ? m1_wr_en_i : m0_wr_en_i;
        addr_q  <= (grant == M1) ? m1_addr_i  : m0_addr_i;
        wdata_q <= (grant == M1) ? m1_data_i  : m0_data_i;
      end
      if (state == BUSY && done) begin
        err_q <= !mem_ack_i;
        if (owner == M1) m1_data_q <= cap_data;
        else             m0_data_q <= cap_data;
      end
    end
  end

  assign mem_rd_en_o = (state == BUSY) && !op_wr;
  assign mem_wr_en_o = (state == BUSY) &&  op_wr;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = wdata_q;

  assign m0_ack_o  = (state == RESP) && (owner == M0) && !err_q;
  assign m0_err_o  = (state == RESP) && (owner == M0) &&  err_q;
  assign m1_ack_o  = (state == RESP) && (owner == M1) && !err_q;
  assign m1_err_o  = (state == RESP) && (owner == M1) &&  err_q;
  assign m0_data_o = m0_data_q;
  assign m1_data_o = m1_data_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed transactions push expectations, a monitor
// pops and compares on every ack/err pulse. Built with TIMEOUT_CYCLES=4.
module tb_mem_bus_arbiter;

  logic        clk, rst_n;
  logic        m0_rd_en_i, m0_wr_en_i, m1_rd_en_i, m1_wr_en_i;
  logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
  logic [31:0] m0_data_o, m1_data_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        mem_rd_en_o, mem_wr_en_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
  logic        mem_ack_i;

  mem_bus_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_rd_en_i(m0_rd_en_i), .m0_wr_en_i(m0_wr_en_i), .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_rd_en_i(m1_rd_en_i), .m1_wr_en_i(m1_wr_en_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        master;
    logic        err;
    logic [31:0] data;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          strobes;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: acks after mem_wait extra BUSY cycles when respond is set.
  logic        respond, spurious, xor_mode;
  int          mem_wait;
  logic [31:0] mem_rdata;
  int          busy_n;

  always @(negedge clk) begin
    mem_data_i = xor_mode ? (mem_addr_o ^ 32'hCAFE_0000) : mem_rdata;
    if (mem_rd_en_o | mem_wr_en_o) begin
      mem_ack_i = respond && (busy_n == mem_wait);
      busy_n++;
    end else begin
      mem_ack_i = spurious;
      if (!spurious) mem_data_i = 32'hFFFF_FFFF;
      busy_n    = 0;
    end
  end

  // Monitor: tracks each strobe burst, compares against the scoreboard on every response.
  int          seen_n;
  logic        s_wr, s_stable;
  logic [31:0] s_addr, s_wdata;

  always @(negedge clk) begin
    exp_t e;
    logic who;
    if (!rst_n) begin
      seen_n = 0;
    end else begin
      if (mem_rd_en_o | mem_wr_en_o) begin
        if (seen_n == 0) begin
          s_wr = mem_wr_en_o; s_addr = mem_addr_o; s_wdata = mem_data_o; s_stable = 1'b1;
        end else if (mem_wr_en_o !== s_wr || mem_addr_o !== s_addr || mem_data_o !== s_wdata) begin
          s_stable = 1'b0;
        end
        if (mem_rd_en_o & mem_wr_en_o) s_stable = 1'b0;
        seen_n++;
      end
      if (m0_ack_o | m0_err_o | m1_ack_o | m1_err_o) begin
        check("one_owner", int'(m0_ack_o | m0_err_o) + int'(m1_ack_o | m1_err_o), 1);
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e   = sb.pop_front();
          who = m1_ack_o | m1_err_o;
          check("owner", who, e.master);
          check("ack", who ? m1_ack_o : m0_ack_o, !e.err);
          check("err", who ? m1_err_o : m0_err_o, e.err);
          check("rdata", who ? m1_data_o : m0_data_o, e.data);
          check("op_wr", s_wr, e.wr);
          check("addr", s_addr, e.addr);
          if (e.wr) check("wdata", s_wdata, e.wdata);
          check("strobes", seen_n, e.strobes);
          check("stable", s_stable, 1'b1);
        end
        seen_n = 0;
      end
    end
  end

  task automatic push(input logic m, input logic err, input logic [31:0] data, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wdata, input int strobes);
    exp_t e;
    e.master = m; e.err = err; e.data = data; e.wr = wr;
    e.addr = addr; e.wdata = wdata; e.strobes = strobes;
    sb.push_back(e);
  endtask

  // Holds each master's request until its response, then either drops it or moves
  // to the next word while further transactions remain.
  task automatic run(input int n0, input int n1, input int budget);
    int   left0, left1, cyc;
    logic d0, d1;
    left0 = n0; left1 = n1; cyc = 0;
    while ((left0 > 0 || left1 > 0) && cyc < budget) begin
      @(negedge clk);
      d0 = m0_ack_o | m0_err_o;
      d1 = m1_ack_o | m1_err_o;
      @(posedge clk); #1;
      cyc++;
      if (d0 && left0 > 0) begin
        left0--;
        if (left0 == 0) begin m0_rd_en_i = 1'b0; m0_wr_en_i = 1'b0; end
        else m0_addr_i = m0_addr_i + 32'd4;
      end
      if (d1 && left1 > 0) begin
        left1--;
        if (left1 == 0) begin m1_rd_en_i = 1'b0; m1_wr_en_i = 1'b0; end
        else m1_addr_i = m1_addr_i + 32'd4;
      end
    end
    check("run_done", left0 + left1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    m0_rd_en_i = 0; m0_wr_en_i = 0; m0_addr_i = '0; m0_data_i = '0;
    m1_rd_en_i = 0; m1_wr_en_i = 0; m1_addr_i = '0; m1_data_i = '0;
    respond = 1'b1; spurious = 1'b0; xor_mode = 1'b0; mem_wait = 0; mem_rdata = '0;
    busy_n = 0; seen_n = 0; mem_ack_i = 1'b0; mem_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_strobes", {mem_rd_en_o, mem_wr_en_o}, 2'b00);
    check("rst_resp", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 4'b0000);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_mem_data", mem_data_o, 32'h0);
    check("rst_m0_data", m0_data_o, 32'h0);
    check("rst_m1_data", m1_data_o, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // m0 read, acked in the first BUSY cycle.
    mem_wait = 0; mem_rdata = 32'hDEAD_BEEF;
    m0_addr_i = 32'h0000_0010; m0_rd_en_i = 1'b1;
    push(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h10, 32'h0, 1);
    run(1, 0, 20);
    check("m1_data_untouched", m1_data_o, 32'h0);

    // m1 write with three wait states; ack coincides with the timeout boundary.
    mem_wait = 3; mem_rdata = 32'h7777_7777;
    m1_addr_i = 32'h0000_0040; m1_data_i = 32'h1234_5678; m1_wr_en_i = 1'b1;
    push(1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 32'h1234_5678, 4);
    run(0, 1, 20);
    check("m0_data_holds", m0_data_o, 32'hDEAD_BEEF);

    // Both masters read at once.
    mem_wait = 0; xor_mode = 1'b1;
    m0_addr_i = 32'h100; m1_addr_i = 32'h200;
    m0_rd_en_i = 1'b1; m1_rd_en_i = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    push(1'b0, 1'b0, 32'hCAFE_0100, 1'b0, 32'h100, 32'h0, 1);
    push(1'b1, 1'b0, 32'hCAFE_0200, 1'b0, 32'h200, 32'h0, 1);
    push(1'b0, 1'b0, 32'hCAFE_0104, 1'b0, 32'h104, 32'h0, 1);
    push(1'b1, 1'b0, 32'hCAFE_0204, 1'b0, 32'h204, 32'h0, 1);
    run(2, 2, 40);
`else
    push(1'b0, 1'b0, 32'hCAFE_0100, 1'b0, 32'h100, 32'h0, 1);
    push(1'b1, 1'b0, 32'hCAFE_0200, 1'b0, 32'h200, 32'h0, 1);
    run(1, 1, 40);
`endif
    xor_mode = 1'b0;

    // Memory never answers: four strobe cycles, then an error pulse with zero data.
    respond = 1'b0; mem_rdata = 32'h5A5A_5A5A;
    m0_addr_i = 32'h80; m0_rd_en_i = 1'b1;
    push(1'b0, 1'b1, 32'h0, 1'b0, 32'h80, 32'h0, 4);
    run(1, 0, 20);
    check("timeout_data", m0_data_o, 32'h0);

    // Asynchronous reset in the middle of BUSY.
    m0_addr_i = 32'h90; m0_rd_en_i = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("busy_before_rst", mem_rd_en_o, 1'b1);
    #2 rst_n = 1'b0;
    m0_rd_en_i = 1'b0;
    #1;
    check("async_strobes", {mem_rd_en_o, mem_wr_en_o}, 2'b00);
    check("async_resp", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 4'b0000);
    check("async_addr", mem_addr_o, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    respond = 1'b1; mem_wait = 0; mem_rdata = 32'h0BAD_F00D;
    m0_addr_i = 32'hA0; m0_rd_en_i = 1'b1;
    push(1'b0, 1'b0, 32'h0BAD_F00D, 1'b0, 32'hA0, 32'h0, 1);
    run(1, 0, 20);

    // Spurious mem_ack in IDLE, then m0 requests read and write together.
    spurious = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_wait = 1; mem_rdata = 32'h3333_3333;
    m0_addr_i = 32'hC0; m0_data_i = 32'h5555_AAAA;
    m0_rd_en_i = 1'b1; m0_wr_en_i = 1'b1;
    push(1'b0, 1'b0, 32'h0, 1'b1, 32'hC0, 32'h5555_AAAA, 2);
    run(1, 0, 20);
    spurious = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory bus between two masters: m0 (core fetch/load/store port) and m1 (debug loader / DMA).
- One transaction at a time.
- Latches the winning request, drives the memory strobes until the memory acknowledges or a timeout expires, then returns one ack/err pulse with read data to the owner.

Parameters:
- ADDR_WIDTH, 32, address width of both masters and the memory.
- DATA_WIDTH, 32, read/write data width.
- TIMEOUT_CYCLES, 255, BUSY cycles without mem_ack_i before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- m0_rd_en_i  in  1  m0 read request
- m0_wr_en_i  in  1  m0 write request
- m0_addr_i  in  ADDR_WIDTH  m0 address
- m0_data_i  in  DATA_WIDTH  m0 write data
- m0_data_o  out  DATA_WIDTH  m0 read data, valid with m0_ack_o
- m0_ack_o  out  1  m0 completion pulse
- m0_err_o  out  1  m0 timeout error pulse
- m1_rd_en_i, m1_wr_en_i, m1_addr_i, m1_data_i, m1_data_o, m1_ack_o, m1_err_o: same as m0, for m1
- mem_rd_en_o  out  1  memory read strobe
- mem_wr_en_o  out  1  memory write strobe
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_data_o  out  DATA_WIDTH  memory write data
- mem_data_i  in  DATA_WIDTH  memory read data, valid with mem_ack_i
- mem_ack_i  in  1  memory completion

Behaviour:
- Reset (async, any state): state=IDLE; all strobes, acks and errs 0; all data/addr outputs 0; timer 0; owner=m0; RR pointer=m0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - A master requests when rd_en|wr_en is high.
  - If any master requests: choose winner, latch owner, addr, wdata and op; go to BUSY.
  - If both masters have rd_en and wr_en high, write wins.
- BUSY:
  - mem_addr_o and mem_data_o come from the latched registers; exactly one of mem_rd_en_o/mem_wr_en_o is 1.
  - Timer increments each cycle.
  - On mem_ack_i=1: capture mem_data_i (reads only; writes capture 0); go to RESP with err=0.
  - Else, if TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1: go to RESP with err=1 and data 0.
  - mem_ack_i wins over a timeout in the same cycle.
- RESP:
  - Strobes 0; the owner's mN_ack_o (or mN_err_o) is 1 for exactly this cycle; mN_data_o holds the captured data.
  - Non-owner ack/err stay 0. Timer clears.
  - Go to IDLE.
- mN_data_o holds its last value between transactions.
- Latency: request sampled at edge 0 → strobes in cycle 1 → with mem_ack_i in cycle 1, ack in cycle 2. Minimum 3 cycles per transaction, back-to-back issue every 3 cycles.
- Master rule: hold request stable until its ack/err cycle; deassert or change it at the edge closing that cycle. Request changes during BUSY are ignored.
- mem_ack_i in IDLE or RESP is ignored.
- A master not granted keeps waiting; no request is dropped.
- Fixed priority (macro absent): m0 beats m1.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: 1-bit RR pointer, updated in RESP to point at the non-owner. On simultaneous requests the pointed-to master wins; a single requester always wins.
- Undefined: fixed priority, m0 always wins ties; pointer logic absent.

Decomposition:
- Package mem_arb_pkg: state encodings (IDLE=2'b00, BUSY=2'b01, RESP=2'b10) and master index constants (M0=1'b0, M1=1'b1).
- One sub-module, mem_arb_timer: counter with clear/enable and an expired output. It drives the expired output to 0 when TIMEOUT_CYCLES=0.

Test Plan:
- m0 read 0x0000_0010; mem acks the first BUSY cycle with 0xDEAD_BEEF → mem_rd_en_o high 1 cycle with addr 0x10; m0_ack_o pulses the next cycle with m0_data_o=0xDEAD_BEEF; m1_ack_o stays 0.
- m1 write 0x0000_0040 ← 0x1234_5678; mem acks after 3 wait cycles → mem_wr_en_o high 4 cycles with stable addr/data; a single m1_ack_o pulse.
- Both masters read in the same cycle, each holding its request until acked:
  - Fixed priority: m0 served, then m1.
  - ARB_ROUND_ROBIN_EN: alternate grants across 4 transactions (m0, m1, m0, m1).
- TIMEOUT_CYCLES=4, mem never acks → strobe high exactly 4 cycles, m0_err_o pulses, m0_ack_o stays 0, m0_data_o=0.
- Assert rst_n=0 in the middle of BUSY → strobes, acks and errs drop to 0 immediately (async); after release the FSM is in IDLE and a fresh m0 read completes normally.
- Spurious mem_ack_i in IDLE, plus rd_en and wr_en both set on m0 → the spurious ack produces no ack pulse; the transaction issues as a write.
